register_file_scoreboard: RTL and testbench

32 x 32-bit MIPS register file with two combinational read ports, one clocked write port, and a per-register busy scoreboard. Sits in ID; its write port is fed from WB by the 5-bit destination-register mux (rt/rd select), and its busy outputs drive the ID-stage stall logic. Register 0 is hardwired to zero and is never busy.

---
 rtl/register_file_scoreboard_pkg.sv | 26 ++
 rtl/register_file_scoreboard_reg_scoreboard.sv | 52 +++++
 rtl/register_file_scoreboard.sv | 81 ++++++++
 tb/tb_register_file_scoreboard.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/register_file_scoreboard_pkg.sv
// register_file_scoreboard_pkg
//   Shared widths and helpers for the register file and its busy scoreboard.
//   DATA_W   : register width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (register 0 is hardwired)
//   ZERO_REG : address of the hardwired zero register
package register_file_scoreboard_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    // One-hot select of a register address; register 0 never produces a bit.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en,
                                                       input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] sel;
        sel = '0;
        if (en && (addr != ZERO_REG)) begin
            sel[addr] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/register_file_scoreboard_reg_scoreboard.sv
// reg_scoreboard
//   Per-register busy bits tracking outstanding writes between ID and WB.
//   Clk, Reset                   : clock, async active-high reset
//   IssueValid, IssueRegister    : destination of the instruction leaving ID (sets a bit)
//   RegWrite, WriteRegister      : WB write port (clears a bit)
//   ReadRegister1/2              : rs/rt addresses being decoded in ID
//   Busy1/2                      : rs/rt still waiting on a producer not covered by bypass
//   BusyVector                   : raw scoreboard bits
module reg_scoreboard
    import register_file_scoreboard_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                IssueValid,
    input  logic [ADDR_W-1:0]   IssueRegister,
    input  logic                RegWrite,
    input  logic [ADDR_W-1:0]   WriteRegister,
    input  logic [ADDR_W-1:0]   ReadRegister1,
    input  logic [ADDR_W-1:0]   ReadRegister2,
    output logic                Busy1,
    output logic                Busy2,
    output logic [NUM_REGS-1:0] BusyVector
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic                wb_hit1;
    logic                wb_hit2;

    assign set_mask = reg_onehot(IssueValid, IssueRegister);
    assign clr_mask = reg_onehot(RegWrite, WriteRegister);

    // Set is applied after clear so a new producer issued on the same edge
    // as the old one's writeback keeps the register busy. Bit 0 never sets.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    // A writeback in the same cycle reaches the reader through the bypass.
    assign wb_hit1 = RegWrite && (WriteRegister == ReadRegister1);
    assign wb_hit2 = RegWrite && (WriteRegister == ReadRegister2);

    assign Busy1      = busy[ReadRegister1] && !wb_hit1 && !Reset;
    assign Busy2      = busy[ReadRegister2] && !wb_hit2 && !Reset;
    assign BusyVector = busy;

endmodule

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
//   32 x 32-bit register file with two combinational read ports (write-first
//   bypass from WB), one clocked write port and a per-register busy scoreboard.
//   Clk, Reset                 : clock, async active-high reset (clears registers and busy bits)
//   ReadRegister1/2            : rs/rt addresses
//   ReadData1/2                : rs/rt contents, bypassed from WB
//   RegWrite, WriteRegister,
//   WriteData                  : WB write port
//   IssueValid, IssueRegister  : destination of the instruction leaving ID
//   Busy1/2                    : rs/rt stall requests
//   BusyVector                 : raw scoreboard bits
module register_file_scoreboard
    import register_file_scoreboard_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic [ADDR_W-1:0]   ReadRegister1,
    input  logic [ADDR_W-1:0]   ReadRegister2,
    output logic [DATA_W-1:0]   ReadData1,
    output logic [DATA_W-1:0]   ReadData2,
    input  logic                RegWrite,
    input  logic [ADDR_W-1:0]   WriteRegister,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic                IssueValid,
    input  logic [ADDR_W-1:0]   IssueRegister,
    output logic                Busy1,
    output logic                Busy2,
    output logic [NUM_REGS-1:0] BusyVector
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Entry 0 is reset and never written, so it always holds zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && (WriteRegister != ZERO_REG)) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    // Reset forces zero so a WB bypass cannot leak out while in reset.
    always_comb begin
        ReadData1 = '0;
        if (!Reset && (ReadRegister1 != ZERO_REG)) begin
            if (RegWrite && (WriteRegister == ReadRegister1)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = regs[ReadRegister1];
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (!Reset && (ReadRegister2 != ZERO_REG)) begin
            if (RegWrite && (WriteRegister == ReadRegister2)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = regs[ReadRegister2];
            end
        end
    end

    reg_scoreboard u_scoreboard (
        .Clk           (Clk),
        .Reset         (Reset),
        .IssueValid    (IssueValid),
        .IssueRegister (IssueRegister),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .Busy1         (Busy1),
        .Busy2         (Busy2),
        .BusyVector    (BusyVector)
    );

endmodule

// File: tb/tb_register_file_scoreboard.sv
module tb_register_file_scoreboard;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ReadRegister1, ReadRegister2;
    logic [31:0] ReadData1, ReadData2;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        IssueValid;
    logic [4:0]  IssueRegister;
    logic        Busy1, Busy2;
    logic [31:0] BusyVector;

    register_file_scoreboard dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .IssueValid    (IssueValid),
        .IssueRegister (IssueRegister),
        .Busy1         (Busy1),
        .Busy2         (Busy2),
        .BusyVector    (BusyVector)
    );

    always #5 Clk = ~Clk;

    // Field-select bits for an expectation.
    localparam logic [4:0] M_RD1 = 5'b00001;
    localparam logic [4:0] M_RD2 = 5'b00010;
    localparam logic [4:0] M_B1  = 5'b00100;
    localparam logic [4:0] M_B2  = 5'b01000;
    localparam logic [4:0] M_BV  = 5'b10000;

    typedef struct {
        string       name;
        logic [4:0]  mask;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic [31:0] bv;
    } exp_t;

    exp_t queue_exp [$];
    event chk_ev;
    int   tests  = 0;
    int   failed = 0;

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: pops every pending expectation and compares against the outputs.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            while (queue_exp.size() > 0) begin
                e = queue_exp.pop_front();
                if (e.mask[0]) cmp(e.name, "ReadData1", ReadData1, e.rd1);
                if (e.mask[1]) cmp(e.name, "ReadData2", ReadData2, e.rd2);
                if (e.mask[2]) cmp(e.name, "Busy1", {31'd0, Busy1}, {31'd0, e.b1});
                if (e.mask[3]) cmp(e.name, "Busy2", {31'd0, Busy2}, {31'd0, e.b2});
                if (e.mask[4]) cmp(e.name, "BusyVector", BusyVector, e.bv);
            end
        end
    end

    task automatic expect_out(input string name, input logic [4:0] mask,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic b1, input logic b2, input logic [31:0] bv);
        exp_t e;
        e.name = name; e.mask = mask; e.rd1 = rd1; e.rd2 = rd2;
        e.b1 = b1; e.b2 = b2; e.bv = bv;
        queue_exp.push_back(e);
        ->chk_ev;
        #2;
    endtask

    // Apply one cycle of stimulus just after the falling edge.
    task automatic drive(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ir,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge Clk);
        RegWrite = rw; WriteRegister = wr; WriteData = wd;
        IssueValid = iv; IssueRegister = ir;
        ReadRegister1 = r1; ReadRegister2 = r2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hFFFF_FFFF;
        IssueValid = 1'b1; IssueRegister = 5'd6;
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd6;
        #1;
        // Outputs stay quiet in reset even with a WB hit on the read address.
        expect_out("reset_hold", M_RD1 | M_RD2 | M_B1 | M_B2 | M_BV, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge Clk);
        expect_out("reset_edge", M_RD1 | M_BV, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        Reset = 1'b0;
        #1;
        expect_out("post_reset", M_RD1 | M_RD2 | M_B1 | M_B2 | M_BV, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Write reg 5 and issue reg 7, then reset asynchronously mid-cycle.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd7, 5'd5, 5'd7);
        #1;
        expect_out("wr5_bypass", M_RD1 | M_B2 | M_BV, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7);
        #1;
        expect_out("wr5_stored", M_RD1 | M_B2 | M_BV, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 32'h0000_0080);
        Reset = 1'b1;
        #1;
        expect_out("async_reset", M_RD1 | M_B2 | M_BV, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7);
        Reset = 1'b0;
        #1;
        expect_out("after_reset", M_RD1 | M_B2 | M_BV, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Zero register: writes and issues to 0 are discarded.
        drive(1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        expect_out("zero_same", M_RD1 | M_RD2 | M_B1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        expect_out("zero_after", M_RD1 | M_B1 | M_BV, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Write/read reg 8, reg 9 untouched.
        drive(1'b1, 5'd8, 32'h0000_00AA, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd8, 5'd9);
        #1;
        expect_out("rd8_rd9", M_RD1 | M_RD2, 32'h0000_00AA, 32'h0, 1'b0, 1'b0, 32'h0);

        // Bypass: reg 10 holds 1, overwritten with 0x55 while being read.
        drive(1'b1, 5'd10, 32'h1, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd8);
        #1;
        expect_out("rd10_old", M_RD1 | M_RD2, 32'h1, 32'h0000_00AA, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 5'd10, 32'h55, 1'b0, 5'd0, 5'd10, 5'd10);
        #1;
        expect_out("bypass10", M_RD1 | M_RD2, 32'h55, 32'h55, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0);
        #1;
        expect_out("stored10", M_RD1 | M_RD2, 32'h55, 32'h0, 1'b0, 1'b0, 32'h0);

        // Scoreboard: issue 12, wait, write back 12.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd0);
        #1;
        expect_out("issue12_pre", M_B1 | M_BV, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd12);
        #1;
        expect_out("busy12", M_B1 | M_B2 | M_BV, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_1000);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
        #1;
        expect_out("busy12_hold", M_B1 | M_B2, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 5'd12, 32'h77, 1'b0, 5'd0, 5'd12, 5'd0);
        #1;
        expect_out("wb12_bypass", M_RD1 | M_B1 | M_BV, 32'h77, 32'h0, 1'b0, 1'b0, 32'h0000_1000);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
        #1;
        expect_out("wb12_clear", M_RD1 | M_B1 | M_BV, 32'h77, 32'h0, 1'b0, 1'b0, 32'h0);

        // Same-edge set and clear of 12: set wins.
        drive(1'b1, 5'd12, 32'h88, 1'b1, 5'd12, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd12, 5'd12);
        #1;
        expect_out("setclr12", M_RD1 | M_B2 | M_BV, 32'h88, 32'h0, 1'b0, 1'b1, 32'h0000_1000);
        // Clear 3 while setting 4; also re-issue 12 (stays set).
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 5'd3, 5'd4);
        #1;
        expect_out("w3_i4_pre", M_RD1 | M_B1 | M_B2 | M_BV, 32'h33, 32'h0, 1'b0, 1'b0, 32'h0000_1008);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd4, 5'd3);
        #1;
        expect_out("w3_i4_post", M_RD2 | M_B1 | M_B2 | M_BV, 32'h0, 32'h33, 1'b1, 1'b0, 32'h0000_1010);
        // Busy2 masked by a same-cycle writeback of 4; Busy1 on 12 unaffected.
        drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd12, 5'd4);
        #1;
        expect_out("mask4", M_RD2 | M_B1 | M_B2 | M_BV, 32'h0, 32'h44, 1'b1, 1'b0, 32'h0000_1010);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd12);
        #1;
        expect_out("final_bv", M_RD1 | M_RD2 | M_B1 | M_B2 | M_BV, 32'h44, 32'h88, 1'b0, 1'b1, 32'h0000_1000);

        #5;
        tests++;
        if (queue_exp.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending, expected 0", queue_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
